// File: rtl/iconn_egress.sv
// iconn_egress: network exit port; checks destination (ICONN_EGRESS_ADDR_CHECK_EN), buffers words, feeds the local consumer.
// Latency: a word at net_* in cycle N is at dout in cycle N+2 when the FIFO is empty.
// Backpressure: none toward the network (overflow/misroute drop and count); dout side is valid/ready.

module iconn_egress_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [PTR_W:0]   count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head; a push into a full FIFO overwrites the slot being popped this same edge.
    assign head_dat = mem[rd_ptr];
endmodule

module iconn_egress #(
    parameter int NODE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH      = 64,
    parameter int NODE_ID         = 0,
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NODE_ADDR_WIDTH-1:0] net_ain,
    input  logic [DATA_WIDTH-1:0]      net_din,
    input  logic                       net_din_valid,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       almost_full,
    output logic                       ovf_err,
    output logic                       mis_err,
    output logic [CNT_WIDTH-1:0]       rx_cnt,
    output logic [CNT_WIDTH-1:0]       drop_cnt,
    input  logic                       clr_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(FIFO_DEPTH - 2);

    logic                       s0_vld;
    logic [NODE_ADDR_WIDTH-1:0] s0_addr;
    logic [DATA_WIDTH-1:0]      s0_dat;

    logic                  addr_ok;
    logic                  pop;
    logic                  push;
    logic                  can_accept;
    logic                  mis_drop;
    logic                  ovf_drop;
    logic [PTR_W:0]        fifo_count;
    logic [DATA_WIDTH-1:0] head_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
        end else begin
            s0_vld <= net_din_valid;
        end
    end

    always_ff @(posedge clk) begin
        s0_addr <= net_ain;
        s0_dat  <= net_din;
    end

`ifdef ICONN_EGRESS_ADDR_CHECK_EN
    assign addr_ok = (s0_addr == NODE_ADDR_WIDTH'(NODE_ID));
`else
    logic unused_addr;
    assign unused_addr = ^s0_addr;
    assign addr_ok     = 1'b1;
`endif

    assign dout_valid  = (fifo_count != '0);
    assign pop         = dout_valid && dout_ready;
    assign can_accept  = (fifo_count < DEPTH_C) || pop;
    // Misroute wins over overflow so a word is never counted twice.
    assign mis_drop    = s0_vld && !addr_ok;
    assign ovf_drop    = s0_vld && addr_ok && !can_accept;
    assign push        = s0_vld && addr_ok && can_accept;
    assign dout        = dout_valid ? head_dat : '0;
    assign almost_full = (fifo_count >= AF_C);

    iconn_egress_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (s0_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt <= '0;
        end else if (push) begin
            rx_cnt <= rx_cnt + CNT_WIDTH'(1);
        end
    end

    // clr_err beats a coincident drop: that drop is intentionally lost from the statistics.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_err) begin
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (ovf_drop) ovf_err <= 1'b1;
            if ((mis_drop || ovf_drop) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef ICONN_EGRESS_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clr_err) begin
            mis_err <= 1'b0;
        end else if (mis_drop) begin
            mis_err <= 1'b1;
        end
    end
`else
    assign mis_err = 1'b0;
`endif
endmodule

// File: doc/iconn_egress.md
# iconn_egress

Receiving end of the interconnect network. It sits behind the last switch stage at one destination node and accepts the per-port triple (address, data, valid) leaving the network. It checks that each word arrived at the correct node, buffers accepted words in a FIFO and hands them to the local consumer over a valid/ready handshake. The network is bufferless with no backpressure, so overflow and misroute are reported through sticky error flags and counters, never by stalling.

## Interface
- NODE_ADDR_WIDTH, 5, width of the destination node address carried with each word
- DATA_WIDTH, 64, payload width
- NODE_ID, 0, address of this node; words with any other address are misrouted
- FIFO_DEPTH, 8, buffer entries; power of two, ≥4
- CNT_WIDTH, 16, width of rx_cnt and drop_cnt
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- net_ain  in  NODE_ADDR_WIDTH  destination address from the final network stage
- net_din  in  DATA_WIDTH  payload from the final network stage
- net_din_valid  in  1  word present this cycle
- dout  out  DATA_WIDTH  head-of-FIFO payload; 0 when dout_valid=0
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts head word
- almost_full  out  1  FIFO occupancy ≥ FIFO_DEPTH-2; upstream scheduler throttles injection on it
- ovf_err  out  1  sticky; a word was dropped because the FIFO was full
- mis_err  out  1  sticky; a word arrived with net_ain ≠ NODE_ID
- rx_cnt  out  CNT_WIDTH  words written to the FIFO; wraps modulo 2^CNT_WIDTH
- drop_cnt  out  CNT_WIDTH  words dropped (overflow + misroute); saturates at all-ones
- clr_err  in  1  single-cycle pulse; clears ovf_err, mis_err, drop_cnt

## Operation
- Stage S0: on every clk edge, register net_ain, net_din and net_din_valid. The capture is unconditional and has no enable.
- Stage S1 decision, using S0 contents:
  - S0 valid, address matches, FIFO can accept: write to FIFO, rx_cnt+1.
  - S0 valid, address mismatch: discard, set mis_err, drop_cnt+1.
  - S0 valid, address matches, FIFO cannot accept: discard, set ovf_err, drop_cnt+1.
- The misroute check has priority over the overflow check. A word counts as one drop only, even if both conditions hold.
- FIFO can accept when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop happens in the same cycle.
- Pop occurs when dout_valid && dout_ready. With dout_valid=0, dout_ready is ignored.
- FIFO behaviour:
  - Show-ahead: dout reflects the head entry combinationally from the read pointer.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - count is log2(FIFO_DEPTH)+1 bits.
  - A simultaneous push and pop leaves count unchanged.
- Counters and flags:
  - drop_cnt holds at 2^CNT_WIDTH-1.
  - rx_cnt wraps to 0.
  - If clr_err and a new drop coincide, clr_err wins: flags and drop_cnt end the cycle at 0, and that drop is lost from the statistics.
- No state machine beyond S0/FIFO. The block is always ready at the network side.

## Timing
- Reset: while rst_n=0 at a clk edge, the following are cleared:
  - S0 valid, pointers, count, rx_cnt, drop_cnt, ovf_err, mis_err.
  - As a result, dout=0, dout_valid=0, almost_full=0.
- Reset mid-operation discards S0 and all FIFO contents. No words are delivered after reset until new input arrives.
- Latency, word presented at net_* in cycle N:
  - Captured at the end of N.
  - Written at the end of N+1.
  - dout_valid=1 and dout valid in cycle N+2 when the FIFO was empty.
- Back-to-back: one word per cycle sustained, provided dout_ready=1 every cycle.
- almost_full, ovf_err, mis_err, rx_cnt and drop_cnt are all registered or derived only from registered state.
- Flag and counter updates become visible the cycle after the S1 decision, i.e. in cycle N+2 for input in N.
- clr_err takes effect at the edge ending its cycle.

## Configuration
- ICONN_EGRESS_ADDR_CHECK_EN defined:
  - Address compare active as described.
- ICONN_EGRESS_ADDR_CHECK_EN not defined:
  - Every valid S0 word is treated as matching; net_ain is ignored.
  - mis_err is tied to 0.
  - drop_cnt counts overflow drops only.

## Test plan
- Reset then single word (net_ain=NODE_ID, net_din=0xA5, valid in cycle 0), dout_ready=1 → dout_valid=1 with dout=0xA5 in cycle 2 only, rx_cnt=1, drop_cnt=0.
- 8 matching words back-to-back, FIFO_DEPTH=8, dout_ready=0 → almost_full=1 from 6 entries, all 8 stored, 9th word → ovf_err=1, drop_cnt=1. Drain → data 1..8 in order.
- Full FIFO with dout_ready=1 and a new word in the same cycle → word accepted, ovf_err stays 0, count stays 8.
- Word with net_ain=NODE_ID+1 → not delivered, mis_err=1, drop_cnt=1. clr_err pulse → mis_err=0, drop_cnt=0. Rebuild without the macro → same word delivered, mis_err=0.
- Preload drop_cnt to all-ones via repeated misroutes (CNT_WIDTH=4, 16 drops) → stays 15. clr_err coincident with a new drop → 0.
- Assert rst_n=0 for one cycle with 5 words buffered and one in S0 → next cycle dout_valid=0, dout=0, counters 0, no stale word emitted.
